// File: rtl/fnd_pkg.sv
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared types and constants for the six-digit FND scan path:
//                scan FSM states, digit positions, blink field codes and the
//                all-off segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fnd_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Digit positions in scan order
    localparam logic [2:0] DIG_SEC_ONE  = 3'd0;
    localparam logic [2:0] DIG_SEC_TEN  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONE  = 3'd2;
    localparam logic [2:0] DIG_MIN_TEN  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONE = 3'd4;
    localparam logic [2:0] DIG_HOUR_TEN = 3'd5;

    // Blink field selector codes
    localparam logic [1:0] BLINK_NONE = 2'd0;
    localparam logic [1:0] BLINK_SEC  = 2'd1;
    localparam logic [1:0] BLINK_MIN  = 2'd2;
    localparam logic [1:0] BLINK_HOUR = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Which time field a digit position belongs to, as a blink field code
    function automatic logic [1:0] digit_field(input logic [2:0] idx);
        logic [1:0] f;
        f = BLINK_NONE;
        case (idx)
            DIG_SEC_ONE,  DIG_SEC_TEN:  f = BLINK_SEC;
            DIG_MIN_ONE,  DIG_MIN_TEN:  f = BLINK_MIN;
            DIG_HOUR_ONE, DIG_HOUR_TEN: f = BLINK_HOUR;
            default:                    f = BLINK_NONE;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_scan_ctrl_if.sv
// ============================================================================
//  Module      : fnd_scan_ctrl_if
//  Description : Time-field inputs and FND pin outputs of the scan controller.
//                slave = scan controller side, master = datapath/board side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fnd_scan_ctrl_if;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [5:0] i_hour;
    logic [1:0] i_blink_pos;
    logic       i_blink_clk;
    logic [5:0] o_seg_enb;
    logic [6:0] o_seg;
    logic       o_frame;

    modport slave (
        input  i_sec, i_min, i_hour, i_blink_pos, i_blink_clk,
        output o_seg_enb, o_seg, o_frame
    );

    modport master (
        output i_sec, i_min, i_hour, i_blink_pos, i_blink_clk,
        input  o_seg_enb, o_seg, o_frame
    );
endinterface

`default_nettype wire

// File: rtl/fnd_dec.sv
// ============================================================================
//  Module      : fnd_dec
//  Description : Decimal digit to seven-segment decoder, segments {a..g}
//                active-high. Codes above 9 decode to all segments off.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_dec
    import fnd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Pure lookup; the caller registers the result
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0: o_seg = 7'b111_1110;
            4'd1: o_seg = 7'b011_0000;
            4'd2: o_seg = 7'b110_1101;
            4'd3: o_seg = 7'b111_1001;
            4'd4: o_seg = 7'b011_0011;
            4'd5: o_seg = 7'b101_1011;
            4'd6: o_seg = 7'b101_1111;
            4'd7: o_seg = 7'b111_0000;
            4'd8: o_seg = 7'b111_1111;
            4'd9: o_seg = 7'b111_0011;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_timer.sv
// ============================================================================
//  Module      : fnd_scan_timer
//  Description : Slot counter, BLANK/DRIVE sequencer and digit index for the
//                FND scan. Exposes the next state/index so the parent can
//                register its outputs in step with the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_timer
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
)(
    input  logic       clk,
    input  logic       rst,
    output state_t     o_state,
    output logic [2:0] o_idx,
    output logic       o_slot_start,
    output logic       o_frame_end,
    output state_t     o_nxt_state,
    output logic [2:0] o_nxt_idx
);

    localparam logic [19:0] c_blank_last = 20'(BLANK_CYC - 1);
    localparam logic [19:0] c_slot_last  = 20'(SCAN_DIV - 1);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [19:0] r_cnt;
    logic        r_frame_end;

    state_t      w_nxt_state;
    logic [2:0]  w_nxt_idx;
    logic [19:0] w_nxt_cnt;
    logic        w_nxt_frame_end;

    // State, index, slot counter and frame pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BLANK;
            r_idx       <= DIG_SEC_ONE;
            r_cnt       <= '0;
            r_frame_end <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_cnt       <= w_nxt_cnt;
            r_frame_end <= w_nxt_frame_end;
        end
    end

    // Next-state: counter runs across the whole slot, clears on slot end
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt + 20'd1;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last)
                    w_nxt_state = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (r_cnt == c_slot_last) begin
                    w_nxt_state = ST_BLANK;
                    w_nxt_cnt   = '0;
                    w_nxt_idx   = (r_idx == DIG_HOUR_TEN) ? DIG_SEC_ONE : r_idx + 3'd1;
                end
            end
            default: begin
                w_nxt_state = ST_BLANK;
                w_nxt_idx   = DIG_SEC_ONE;
                w_nxt_cnt   = '0;
            end
        endcase
        // Frame pulse is registered so it lines up with the last DRIVE cycle
        w_nxt_frame_end = (w_nxt_state == ST_DRIVE) && (w_nxt_idx == DIG_HOUR_TEN) &&
                          (w_nxt_cnt == c_slot_last);
    end

    assign o_state      = r_state;
    assign o_idx        = r_idx;
    assign o_slot_start = (r_state == ST_BLANK) && (r_cnt == 20'd0);
    assign o_frame_end  = r_frame_end;
    assign o_nxt_state  = w_nxt_state;
    assign o_nxt_idx    = w_nxt_idx;

endmodule

`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
// ============================================================================
//  Module      : fnd_scan_ctrl
//  Description : Six-digit time-multiplexed FND scan controller with blanking
//                between digits and a once-per-frame snapshot of the time.
//                Optional macro FND_BLINK_EN: hide the selected field's digits
//                while i_blink_clk is low.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
)(
    input  logic            clk,
    input  logic            rst,
    fnd_scan_ctrl_if.slave  bus
);

    state_t     w_state;
    state_t     w_nxt_state;
    logic [2:0] w_idx;
    logic [2:0] w_nxt_idx;
    logic       w_slot_start;
    logic       w_frame_end;

    logic [5:0] r_sec;
    logic [5:0] r_min;
    logic [5:0] r_hour;
    logic [6:0] r_seg;
    logic [5:0] r_seg_enb;

    logic       w_take;
    logic [5:0] w_sec;
    logic [5:0] w_min;
    logic [5:0] w_hour;
    logic [5:0] w_val;
    logic [3:0] w_digit;
    logic       w_oor;
    logic [6:0] w_dec_seg;
    logic [5:0] w_enb_nxt;

    fnd_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_state      (w_state),
        .o_idx        (w_idx),
        .o_slot_start (w_slot_start),
        .o_frame_end  (w_frame_end),
        .o_nxt_state  (w_nxt_state),
        .o_nxt_idx    (w_nxt_idx)
    );

    // Digit 0 decodes straight from the inputs on the capture cycle so the
    // whole frame, including its first digit, shows the same snapshot
    assign w_take = w_slot_start && (w_idx == DIG_SEC_ONE);
    assign w_sec  = w_take ? bus.i_sec  : r_sec;
    assign w_min  = w_take ? bus.i_min  : r_min;
    assign w_hour = w_take ? bus.i_hour : r_hour;

    // Pick the field for the current digit and split it into tens/ones
    always_comb begin
        w_val = 6'd0;
        case (digit_field(w_idx))
            BLINK_SEC:  w_val = w_sec;
            BLINK_MIN:  w_val = w_min;
            BLINK_HOUR: w_val = w_hour;
            default:    w_val = 6'd0;
        endcase
        // Odd positions are the tens digits
        w_digit = w_idx[0] ? 4'(w_val / 6'd10) : 4'(w_val % 6'd10);
        w_oor   = (w_val > 6'd59);
    end

    fnd_dec u_dec (
        .i_digit (w_digit),
        .o_seg   (w_dec_seg)
    );

    // Enable pattern for the coming cycle, so the pins track the sequencer
    always_comb begin
        w_enb_nxt = 6'b11_1111;
        if (w_nxt_state == ST_DRIVE) begin
            w_enb_nxt[w_nxt_idx] = 1'b0;
`ifdef FND_BLINK_EN
            if (!bus.i_blink_clk && (bus.i_blink_pos != BLINK_NONE) &&
                (bus.i_blink_pos == digit_field(w_nxt_idx)))
                w_enb_nxt = 6'b11_1111;
`endif
        end
    end

    // Snapshot, segment and enable output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_hour    <= 6'd0;
            r_seg     <= SEG_BLANK;
            r_seg_enb <= 6'b11_1111;
        end else begin
            if (w_take) begin
                r_sec  <= bus.i_sec;
                r_min  <= bus.i_min;
                r_hour <= bus.i_hour;
            end
            if (w_slot_start)
                r_seg <= w_oor ? SEG_BLANK : w_dec_seg;
            r_seg_enb <= w_enb_nxt;
        end
    end

    assign bus.o_seg_enb = r_seg_enb;
    assign bus.o_seg     = r_seg;
    assign bus.o_frame   = w_frame_end;

    // Blink inputs are only consumed when the blink feature is built in
    logic w_unused;
    assign w_unused = ^{bus.i_blink_pos, bus.i_blink_clk, w_state == ST_DRIVE};

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
// ============================================================================
//  Module      : tb_fnd_scan_ctrl
//  Description : Directed self-checking bench for fnd_scan_ctrl with
//                SCAN_DIV=8, BLANK_CYC=2 (48-cycle frames).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fnd_scan_ctrl;

    logic clk;
    logic rst;

    fnd_scan_ctrl_if u_if();

    fnd_scan_ctrl #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Standard digit patterns {a..g}
    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b111_1110;
            1: return 7'b011_0000;
            2: return 7'b110_1101;
            3: return 7'b111_1001;
            4: return 7'b011_0011;
            5: return 7'b101_1011;
            6: return 7'b101_1111;
            7: return 7'b111_0000;
            8: return 7'b111_1111;
            9: return 7'b111_0011;
            default: return 7'b000_0000;
        endcase
    endfunction

    // Timeline model state: k = cycles since rst dropped
    int         k;
    logic [6:0] m_seg;
    int         m_sec, m_min, m_hour;
    logic [1:0] m_bpos;
    logic       m_bclk;

    function automatic logic [6:0] exp_digit(input int slot);
        int v;
        v = (slot < 2) ? m_sec : (slot < 4) ? m_min : m_hour;
        if (v > 59) return 7'b000_0000;
        return (slot % 2 == 1) ? pat(v / 10) : pat(v % 10);
    endfunction

    // Check the current cycle against the model, then advance one clock
    task automatic step();
        int slot, pos;
        logic [5:0] e_enb;
        slot  = (k / 8) % 6;
        pos   = k % 8;
        e_enb = 6'b11_1111;
        if (pos >= 2) begin
            e_enb[slot] = 1'b0;
`ifdef FND_BLINK_EN
            if (!m_bclk && m_bpos != 2'd0 && int'(m_bpos) == slot / 2 + 1)
                e_enb = 6'b11_1111;
`endif
        end
        check_eq($sformatf("enb k=%0d", k), u_if.o_seg_enb, e_enb);
        check_eq($sformatf("seg k=%0d", k), u_if.o_seg, m_seg);
        check_eq($sformatf("frame k=%0d", k), u_if.o_frame, (k % 48 == 47) ? 1 : 0);
        if (k % 48 == 0) begin
            m_sec  = u_if.i_sec;
            m_min  = u_if.i_min;
            m_hour = u_if.i_hour;
        end
        if (pos == 0) m_seg = exp_digit(slot);
        m_bpos = u_if.i_blink_pos;
        m_bclk = u_if.i_blink_clk;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " enb"},   u_if.o_seg_enb, 6'b11_1111);
        check_eq({tag, " seg"},   u_if.o_seg,     7'b000_0000);
        check_eq({tag, " frame"}, u_if.o_frame,   1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        u_if.i_hour      = 6'd12;
        u_if.i_min       = 6'd34;
        u_if.i_sec       = 6'd56;
        u_if.i_blink_pos = 2'd0;
        u_if.i_blink_clk = 1'b1;
        m_bpos = 2'd0;
        m_bclk = 1'b1;
        m_sec = 0; m_min = 0; m_hour = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // Release reset: scan of 12:34:56
        rst   = 1'b0;
        k     = 0;
        m_seg = 7'b000_0000;
        while (k < 96) begin
            // Mid-frame seconds change during digit 3 shows up next frame
            if (k == 28) u_if.i_sec = 6'd57;
            step();
        end

        // Out-of-range minutes blank digits 2 and 3
        u_if.i_min = 6'd63;
        while (k < 144) step();

        // Blink request on minutes, then release blink phase
        u_if.i_min       = 6'd34;
        u_if.i_blink_pos = 2'd2;
        u_if.i_blink_clk = 1'b0;
        while (k < 192) begin
            if (k == 180) u_if.i_blink_clk = 1'b1;
            step();
        end

        // One-cycle reset during digit 4 DRIVE
        while (k < 228) step();
        rst = 1'b1;
        step();
        check_reset_vals("midreset");
        rst         = 1'b0;
        u_if.i_sec  = 6'd10;
        u_if.i_hour = 6'd23;
        k     = 0;
        m_seg = 7'b000_0000;
        while (k < 100) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
